// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Build option: define CLK_DIV_TICK_EN to generate the per-channel tick pulse.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Ratios below 2 cannot produce a high and a low phase, so they are raised to 2.
  function automatic div_t clamp_div(input div_t v);
    return (v < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active/pending ratio, registered waveform.
// Build option: CLK_DIV_TICK_EN adds the rising-edge tick flop.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_pend_vld
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_act_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend_vld;
  logic             r_run;
  logic             r_clk_out;

  logic [DIV_W-1:0] w_cnt_inc;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_load_val;
  logic             w_last;
  logic             w_start;

  assign w_cnt_inc  = r_cnt + DIV_W'(1);
  // ceil(N/2) without needing an extra bit for N+1
  assign w_half     = (r_act_div >> 1) + DIV_W'(r_act_div[0]);
  assign w_load_val = (i_load_val < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_load_val;
  assign w_last     = (r_cnt == r_act_div - DIV_W'(1));
  // Phase 0 begins either on the enabling edge or on a period wrap.
  assign w_start    = i_en && (!r_run || w_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_act_div  <= DIV_W'(DEF_DIV);
      r_pend_div <= DIV_W'(DEF_DIV);
      r_pend_vld <= 1'b0;
      r_run      <= 1'b0;
      r_clk_out  <= 1'b0;
    end else begin
      if (!i_en) begin
        r_cnt     <= '0;
        r_run     <= 1'b0;
        r_clk_out <= 1'b0;
        if (r_pend_vld) begin
          r_act_div  <= r_pend_div;
          r_pend_vld <= 1'b0;
        end
      end else if (w_start) begin
        r_cnt     <= '0;
        r_run     <= 1'b1;
        r_clk_out <= 1'b1;
        if (r_run && r_pend_vld) begin
          r_act_div  <= r_pend_div;
          r_pend_vld <= 1'b0;
        end
      end else begin
        r_cnt     <= w_cnt_inc;
        r_clk_out <= (w_cnt_inc < w_half);
      end
      // A write landing on a boundary edge is queued for the following boundary.
      if (i_load) begin
        r_pend_div <= w_load_val;
        r_pend_vld <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  logic r_tick;
  always_ff @(posedge clk) begin
    if (rst) r_tick <= 1'b0;
    else     r_tick <= w_start;
  end
  assign o_tick = r_tick;
`else
  assign o_tick = 1'b0;
`endif

  assign o_clk_out  = r_clk_out;
  assign o_pend_vld = r_pend_vld;

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel runtime-programmable clock divider with boundary-aligned ratio updates.
// Build option: CLK_DIV_TICK_EN enables the tick outputs (tied low otherwise).
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int  CH      = 4,
  parameter int  DIV_W   = DIV_W_DEF,
  parameter int  DEF_DIV = 4,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic [CH_W-1:0]  div_ch,
  input  logic [DIV_W-1:0] div_val,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick
);

  logic [CH-1:0] w_pend_vld;
  logic [CH-1:0] w_load;
  logic          w_ready;

  // Out-of-range channels stay ready so their writes are accepted and dropped.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (div_ch == CH_W'(i)) w_ready = !w_pend_vld[i];
    end
  end

  assign div_ready = w_ready;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      assign w_load[gi] = div_valid && w_ready && (div_ch == CH_W'(gi));

      clk_div_chan #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en[gi]),
        .i_load     (w_load[gi]),
        .i_load_val (div_val),
        .o_clk_out  (clk_out[gi]),
        .o_tick     (tick[gi]),
        .o_pend_vld (w_pend_vld[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench: hand tables, directed corner sequences and a random run vs a phase model.
module tb_clk_divider_prog;

  localparam int CH      = 4;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 4;
`ifdef CLK_DIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    en;
  logic             div_valid;
  logic             div_ready;
  logic [1:0]       div_ch;
  logic [DIV_W-1:0] div_val;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;

  int errors = 0;
  int checks = 0;

  clk_divider_prog #(.CH(CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .div_valid(div_valid), .div_ready(div_ready),
    .div_ch(div_ch), .div_val(div_val), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current period plus ratio bookkeeping.
  int m_ph[CH];
  int m_act[CH];
  int m_pend[CH];
  bit m_pv[CH];
  bit m_run[CH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  function automatic bit model_ready();
    if (int'(div_ch) < CH) return !m_pv[div_ch];
    return 1'b1;
  endfunction

  function automatic logic [CH-1:0] model_clk();
    logic [CH-1:0] v = '0;
    for (int c = 0; c < CH; c++) v[c] = m_run[c] && (m_ph[c] < (m_act[c] + 1) / 2);
    return v;
  endfunction

  function automatic logic [CH-1:0] model_tick();
    logic [CH-1:0] v = '0;
    for (int c = 0; c < CH; c++) v[c] = TICK_ON && m_run[c] && (m_ph[c] == 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ph[c] = 0; m_act[c] = DEF_DIV; m_pend[c] = DEF_DIV; m_pv[c] = 0; m_run[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = div_valid && model_ready();
    for (int c = 0; c < CH; c++) begin
      if (!en[c]) begin
        m_run[c] = 0; m_ph[c] = 0;
        if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 0; end
      end else if (!m_run[c]) begin
        m_run[c] = 1; m_ph[c] = 0;
      end else if (m_ph[c] == m_act[c] - 1) begin
        m_ph[c] = 0;
        if (m_pv[c]) begin m_act[c] = m_pend[c]; m_pv[c] = 0; end
      end else begin
        m_ph[c]++;
      end
    end
    if (acc && int'(div_ch) < CH) begin
      m_pend[div_ch] = (div_val < 2) ? 2 : int'(div_val);
      m_pv[div_ch]   = 1;
    end
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic step();
    #2;
    check("ready_model", {31'd0, div_ready}, {31'd0, model_ready()});
    @(posedge clk);
    model_edge();
    #1;
    check("clk_out_model", {28'd0, clk_out}, {28'd0, model_clk()});
    check("tick_model", {28'd0, tick}, {28'd0, model_tick()});
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] val;
    logic       rdy;
    logic       clk0;
    logic       tk0;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int n;

    // Ratio 4 on ch0, then a mid-period change to 6 with a rejected second write.
    vecs[0]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'd6, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; en = '0; div_valid = 1'b0; div_ch = '0; div_val = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_clk_out", {28'd0, clk_out}, 32'd0);
    check("reset_tick", {28'd0, tick}, 32'd0);
    check("reset_ready", {31'd0, div_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      en = 4'b0001; div_valid = vecs[i].vld; div_ch = 2'd0; div_val = vecs[i].val;
      #1;
      check($sformatf("vec%0d_ready", i), {31'd0, div_ready}, {31'd0, vecs[i].rdy});
      step();
      check($sformatf("vec%0d_clk_out", i), {28'd0, clk_out}, {31'd0, vecs[i].clk0});
      check($sformatf("vec%0d_tick", i), {28'd0, tick}, {31'd0, vecs[i].tk0 & TICK_ON});
    end
    div_valid = 1'b0;

    // Odd ratio 5 on ch1, loaded while disabled.
    div_valid = 1'b1; div_ch = 2'd1; div_val = 8'd5;
    step();
    div_valid = 1'b0;
    step();
    en = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      step();
      check("odd5_clk", {31'd0, clk_out[1]}, {31'd0, ((k % 5) < 3)});
      check("odd5_tick", {31'd0, tick[1]}, {31'd0, TICK_ON && (k % 5 == 0)});
    end

    // Ratio 1 on ch2 clamps to 2.
    div_valid = 1'b1; div_ch = 2'd2; div_val = 8'd1;
    step();
    div_valid = 1'b0;
    step();
    en = 4'b0111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("clamp2_clk", {31'd0, clk_out[2]}, {31'd0, (k % 2 == 0)});
      check("clamp2_tick", {31'd0, tick[2]}, {31'd0, TICK_ON && (k % 2 == 0)});
    end

    // Disable ch0 at phase 2 of a ratio-6 period, then restart it.
    n = 0;
    while (!(m_run[0] && m_ph[0] == 1 && m_act[0] == 6) && n < 20) begin
      step();
      n++;
    end
    check("ch0_sync_timeout", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    step();
    check("ch0_at_phase2", {31'd0, clk_out[0]}, 32'd1);
    en[0] = 1'b0;
    step();
    check("disable_clk", {31'd0, clk_out[0]}, 32'd0);
    check("disable_tick", {31'd0, tick[0]}, 32'd0);
    step();
    step();
    en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("reen_clk", {31'd0, clk_out[0]}, {31'd0, ((k % 6) < 3)});
      check("reen_tick", {31'd0, tick[0]}, {31'd0, TICK_ON && (k % 6 == 0)});
    end

    // Reset while ch3 holds a pending ratio 9.
    en = 4'b1111;
    step();
    div_valid = 1'b1; div_ch = 2'd3; div_val = 8'd9;
    step();
    div_valid = 1'b0;
    #1;
    check("pend_ready_low", {31'd0, div_ready}, 32'd0);
    rst = 1'b1;
    step();
    check("midrst_clk_out", {28'd0, clk_out}, 32'd0);
    check("midrst_tick", {28'd0, tick}, 32'd0);
    check("midrst_ready", {31'd0, div_ready}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("postrst_ch3", {31'd0, clk_out[3]}, {31'd0, ((k % DEF_DIV) < DEF_DIV / 2)});
    end

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
      div_valid = ($urandom_range(0, 9) < 4);
      div_ch    = 2'($urandom_range(0, CH - 1));
      div_val   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 60));
      step();
    end
    rst = 1'b0; div_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
